// File: rtl/bsg_mcl_req_credit_arbiter.sv
// Round-robin arbiter sharing one registered manycore-link request port among
// several requesters, with a credit counter that bounds outstanding requests.
module bsg_mcl_req_credit_arbiter #(
  parameter int num_req_p   = 2,
  parameter int pkt_width_p = 128,
  parameter int credits_p   = 16,
  localparam int lg_credits_lp = $clog2(credits_p + 1),
  localparam int lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic                             mc_req_v_o,
  output logic [pkt_width_p-1:0]           mc_req_pkt_o,
  input  logic                             mc_req_ready_i,
  input  logic                             credit_return_i,
  input  logic                             drain_i,
  output logic [lg_credits_lp-1:0]         credits_avail_o,
  output logic                             idle_o,
  output logic                             err_o
);

  localparam logic [lg_credits_lp-1:0] credits_max_lp = lg_credits_lp'(credits_p);
  localparam logic [lg_req_lp-1:0]     last_init_lp   = lg_req_lp'(num_req_p - 1);

  logic [pkt_width_p-1:0]   pkt_arr [num_req_p];
  logic [lg_req_lp-1:0]     last_q, last_d;
  logic [lg_credits_lp-1:0] credits_q, credits_d;
  logic                     v_q, v_d;
  logic [pkt_width_p-1:0]   pkt_q, pkt_d;
  logic                     err_q, err_d;
  logic                     out_free, can_grant, grant_v;
  logic [lg_req_lp-1:0]     grant_idx;
  int                       idx;

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
    assign pkt_arr[gi]    = req_pkt_i[gi*pkt_width_p +: pkt_width_p];
    assign req_yumi_o[gi] = grant_v && (grant_idx == lg_req_lp'(gi));
  end

  // No credit bypass: a same-cycle return never enables a grant at zero credits.
  assign out_free  = ~v_q | mc_req_ready_i;
  assign can_grant = out_free & (credits_q != '0) & ~drain_i;

  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < num_req_p; off++) begin
      idx = (int'(last_q) + 1 + off) % num_req_p;
      if (!grant_v && can_grant && req_v_i[idx]) begin
        grant_v   = 1'b1;
        grant_idx = lg_req_lp'(idx);
      end
    end
  end

  always_comb begin
    last_d    = last_q;
    v_d       = v_q;
    pkt_d     = pkt_q;
    credits_d = credits_q;
    err_d     = err_q;
    if (grant_v) begin
      last_d = grant_idx;
      v_d    = 1'b1;
      pkt_d  = pkt_arr[grant_idx];
    end else if (v_q && mc_req_ready_i) begin
      v_d = 1'b0;
    end
    if (grant_v && !credit_return_i) begin
      credits_d = credits_q - 1'b1;
    end else if (credit_return_i && !grant_v) begin
      if (credits_q == credits_max_lp) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q    <= last_init_lp;
      v_q       <= 1'b0;
      pkt_q     <= '0;
      credits_q <= credits_max_lp;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      v_q       <= v_d;
      pkt_q     <= pkt_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign mc_req_v_o      = v_q;
  assign mc_req_pkt_o    = pkt_q;
  assign credits_avail_o = credits_q;
  assign idle_o          = ~v_q & (credits_q == credits_max_lp);
  assign err_o           = err_q;

endmodule

// File: tb/tb_bsg_mcl_req_credit_arbiter.sv
// Randomized bench comparing the credit arbiter against a queue-based reference model.
module tb_bsg_mcl_req_credit_arbiter;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int C  = 16;
  localparam int LC = $clog2(C + 1);

  logic             clk = 1'b0;
  logic             reset_i = 1'b0;
  logic [N-1:0]     req_v_i = '0;
  logic [N*W-1:0]   req_pkt_i = '0;
  logic [N-1:0]     req_yumi_o;
  logic             mc_req_v_o;
  logic [W-1:0]     mc_req_pkt_o;
  logic             mc_req_ready_i = 1'b0;
  logic             credit_return_i = 1'b0;
  logic             drain_i = 1'b0;
  logic [LC-1:0]    credits_avail_o;
  logic             idle_o;
  logic             err_o;

  bsg_mcl_req_credit_arbiter #(
    .num_req_p  (N),
    .pkt_width_p(W),
    .credits_p  (C)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .req_v_i        (req_v_i),
    .req_pkt_i      (req_pkt_i),
    .req_yumi_o     (req_yumi_o),
    .mc_req_v_o     (mc_req_v_o),
    .mc_req_pkt_o   (mc_req_pkt_o),
    .mc_req_ready_i (mc_req_ready_i),
    .credit_return_i(credit_return_i),
    .drain_i        (drain_i),
    .credits_avail_o(credits_avail_o),
    .idle_o         (idle_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: free credits, a queue holding the buffered output packet,
  // the last granted requester and the sticky overflow flag.
  int             m_credits;
  logic [W-1:0]   m_buf[$];
  int             m_last;
  bit             m_err;
  bit             pend[N];
  logic [W-1:0]   pkt[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits = C;
    m_buf.delete();
    m_last = N - 1;
    m_err  = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    credit_return_i = 1'b0;
    drain_i = 1'b0;
    req_v_i = '0;
    model_reset();
    #1;
    check("rst_v", 64'(mc_req_v_o), 64'd0);
    check("rst_credits", 64'(credits_avail_o), 64'(C));
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_yumi", 64'(req_yumi_o), 64'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask

  // One clock of stimulus + comparison + model update.
  task automatic step(input bit ret, input bit rdy, input bit drn, input bit force_req);
    int g;
    bit out_free;
    logic [N-1:0] ey;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (force_req || $urandom_range(0, 3) != 0)) begin
        pend[i] = 1'b1;
        pkt[i]  = {8'(i), 24'($urandom)};
      end
      req_v_i[i] = pend[i];
      req_pkt_i[i*W +: W] = pkt[i];
    end
    mc_req_ready_i  = rdy;
    credit_return_i = ret;
    drain_i         = drn;
    #1;
    g = -1;
    out_free = (m_buf.size() == 0) || rdy;
    if (out_free && m_credits > 0 && !drn)
      for (int off = 0; off < N; off++)
        if (g < 0 && pend[(m_last + 1 + off) % N]) g = (m_last + 1 + off) % N;
    ey = '0;
    if (g >= 0) ey[g] = 1'b1;
    check("yumi", 64'(req_yumi_o), 64'(ey));
    check("v_o", 64'(mc_req_v_o), 64'(m_buf.size() != 0));
    if (m_buf.size() != 0) check("pkt_o", 64'(mc_req_pkt_o), 64'(m_buf[0]));
    check("credits", 64'(credits_avail_o), 64'(m_credits));
    check("idle", 64'(idle_o), 64'((m_buf.size() == 0) && (m_credits == C)));
    check("err", 64'(err_o), 64'(m_err));
    @(posedge clk);
    if (m_buf.size() != 0 && rdy) begin
      $display("[TB] t=%0t pkt %h delivered, credits %0d", $time, m_buf[0], m_credits);
      void'(m_buf.pop_front());
    end
    if (g >= 0) begin
      m_buf.push_back(pkt[g]);
      pend[g] = 1'b0;
      m_last  = g;
    end
    if (g >= 0 && !ret) m_credits--;
    else if (ret && g < 0) begin
      if (m_credits == C) m_err = 1'b1;
      else m_credits++;
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Both requesters continuously, returns once a credit is outstanding.
    for (int i = 0; i < 20; i++) step(m_credits < C, 1'b1, 1'b0, 1'b1);

    // Exhaust credits with no returns, then one return and a few more cycles.
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Refill some credits, then backpressure with a buffered packet.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Drain until idle, then resume.
    for (int i = 0; i < 24; i++) step(m_credits < C, 1'b1, 1'b1, 1'b0);
    check("drain_idle", 64'(idle_o), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step((m_credits < C) && ($urandom_range(0, 1) == 1), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0, 1'b0);

    // Return to full, then an extra return overflows and sets the sticky error.
    for (int i = 0; i < 24; i++) step(m_credits < C, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of traffic clears the buffer, credits and error.
    do_reset();
    for (int i = 0; i < 100; i++)
      step((m_credits < C) && ($urandom_range(0, 1) == 1), $urandom_range(0, 9) < 8,
           $urandom_range(0, 15) == 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
